// File: rtl/dsp_multacc_nx.sv
// N-lane multiply-accumulate with coefficient table, guarded accumulator and
// shift/round/saturate output path; optional input and output pipeline registers.
module dsp_multacc_nx #(
  parameter int                         LANES         = 2,
  parameter int                         A_WIDTH       = 10,
  parameter int                         B_WIDTH       = 9,
  parameter int                         GUARD         = 5,
  parameter logic [LANES*4*A_WIDTH-1:0] COEFFS        = '0,
  parameter string                      INPUT_REG_EN  = "TRUE",
  parameter string                      OUTPUT_REG_EN = "TRUE"
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_in_valid,
  input  logic [LANES*A_WIDTH-1:0]         i_a,
  input  logic [LANES*B_WIDTH-1:0]         i_b,
  input  logic [2:0]                       i_feedback,
  input  logic                             i_load_acc,
  input  logic                             i_subtract,
  input  logic                             i_unsigned_a,
  input  logic                             i_unsigned_b,
  input  logic [4:0]                       i_shift_right,
  input  logic                             i_round,
  input  logic                             i_saturate,
  output logic [LANES*(A_WIDTH+B_WIDTH)-1:0] o_z,
  output logic [LANES*B_WIDTH-1:0]         o_dly_b,
  output logic                             o_out_valid
);

  localparam int Z_W    = A_WIDTH + B_WIDTH;
  localparam int ACC_W  = Z_W + GUARD;
  localparam int R_W    = ACC_W + 1;
  localparam int P_W    = Z_W + 2;
  localparam bit IN_REG  = (INPUT_REG_EN == "TRUE");
  localparam bit OUT_REG = (OUTPUT_REG_EN == "TRUE");

  localparam logic signed [R_W-1:0] SMAX = {{(R_W-Z_W+1){1'b0}}, {(Z_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] SMIN = {{(R_W-Z_W+1){1'b1}}, {(Z_W-1){1'b0}}};
  localparam logic signed [R_W-1:0] UMAX = {{(R_W-Z_W){1'b0}}, {Z_W{1'b1}}};

  logic                       w_s_valid;
  logic [LANES*A_WIDTH-1:0]   w_s_a;
  logic [LANES*B_WIDTH-1:0]   w_s_b;
  logic [2:0]                 w_s_fb;
  logic                       w_s_load;
  logic                       w_s_sub;
  logic                       w_s_ua;
  logic                       w_s_ub;
  logic [4:0]                 w_s_sh;
  logic                       w_s_rnd;
  logic                       w_s_sat;

  logic                       r_acc_valid;
  logic [4:0]                 r_acc_sh;
  logic                       r_acc_rnd;
  logic                       r_acc_sat;
  logic                       r_acc_usat;
  logic [LANES*B_WIDTH-1:0]   r_dly_b;
  logic [LANES*Z_W-1:0]       w_z_all;

  if (IN_REG) begin : g_s0
    logic                     r_s0_valid;
    logic [LANES*A_WIDTH-1:0] r_s0_a;
    logic [LANES*B_WIDTH-1:0] r_s0_b;
    logic [2:0]               r_s0_fb;
    logic                     r_s0_load;
    logic                     r_s0_sub;
    logic                     r_s0_ua;
    logic                     r_s0_ub;
    logic [4:0]               r_s0_sh;
    logic                     r_s0_rnd;
    logic                     r_s0_sat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s0_valid <= 1'b0;
        r_s0_a     <= '0;
        r_s0_b     <= '0;
        r_s0_fb    <= '0;
        r_s0_load  <= 1'b0;
        r_s0_sub   <= 1'b0;
        r_s0_ua    <= 1'b0;
        r_s0_ub    <= 1'b0;
        r_s0_sh    <= '0;
        r_s0_rnd   <= 1'b0;
        r_s0_sat   <= 1'b0;
      end else begin
        r_s0_valid <= i_in_valid;
        if (i_in_valid) begin
          r_s0_a    <= i_a;
          r_s0_b    <= i_b;
          r_s0_fb   <= i_feedback;
          r_s0_load <= i_load_acc;
          r_s0_sub  <= i_subtract;
          r_s0_ua   <= i_unsigned_a;
          r_s0_ub   <= i_unsigned_b;
          r_s0_sh   <= i_shift_right;
          r_s0_rnd  <= i_round;
          r_s0_sat  <= i_saturate;
        end
      end
    end

    assign w_s_valid = r_s0_valid;
    assign w_s_a     = r_s0_a;
    assign w_s_b     = r_s0_b;
    assign w_s_fb    = r_s0_fb;
    assign w_s_load  = r_s0_load;
    assign w_s_sub   = r_s0_sub;
    assign w_s_ua    = r_s0_ua;
    assign w_s_ub    = r_s0_ub;
    assign w_s_sh    = r_s0_sh;
    assign w_s_rnd   = r_s0_rnd;
    assign w_s_sat   = r_s0_sat;
  end else begin : g_s0_bypass
    assign w_s_valid = i_in_valid;
    assign w_s_a     = i_a;
    assign w_s_b     = i_b;
    assign w_s_fb    = i_feedback;
    assign w_s_load  = i_load_acc;
    assign w_s_sub   = i_subtract;
    assign w_s_ua    = i_unsigned_a;
    assign w_s_ub    = i_unsigned_b;
    assign w_s_sh    = i_shift_right;
    assign w_s_rnd   = i_round;
    assign w_s_sat   = i_saturate;
  end

  // Output-path controls travel with the sample into the accumulate stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_valid <= 1'b0;
      r_acc_sh    <= '0;
      r_acc_rnd   <= 1'b0;
      r_acc_sat   <= 1'b0;
      r_acc_usat  <= 1'b0;
      r_dly_b     <= '0;
    end else begin
      r_acc_valid <= w_s_valid;
      if (w_s_valid) begin
        r_acc_sh   <= w_s_sh;
        r_acc_rnd  <= w_s_rnd;
        r_acc_sat  <= w_s_sat;
        r_acc_usat <= w_s_ua & w_s_ub;
      end
      if (i_in_valid) r_dly_b <= i_b;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [A_WIDTH-1:0]      w_coef;
    logic [A_WIDTH-1:0]      w_a_sel;
    logic [B_WIDTH-1:0]      w_b;
    logic signed [A_WIDTH:0] w_a_ext;
    logic signed [B_WIDTH:0] w_b_ext;
    logic signed [P_W-1:0]   w_a_x;
    logic signed [P_W-1:0]   w_b_x;
    logic signed [P_W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_p;
    logic [ACC_W-1:0]        w_acc_next;
    logic [ACC_W-1:0]        r_acc;
    logic [R_W-1:0]          w_rnd_add;
    logic [R_W-1:0]          w_r;
    logic signed [R_W-1:0]   w_s;
    logic [Z_W-1:0]          w_z;

    always_comb begin
      case (w_s_fb[1:0])
        2'd0:    w_coef = COEFFS[(l*4+0)*A_WIDTH +: A_WIDTH];
        2'd1:    w_coef = COEFFS[(l*4+1)*A_WIDTH +: A_WIDTH];
        2'd2:    w_coef = COEFFS[(l*4+2)*A_WIDTH +: A_WIDTH];
        default: w_coef = COEFFS[(l*4+3)*A_WIDTH +: A_WIDTH];
      endcase
    end

    assign w_a_sel = w_s_fb[2] ? w_coef : w_s_a[l*A_WIDTH +: A_WIDTH];
    assign w_b     = w_s_b[l*B_WIDTH +: B_WIDTH];
    assign w_a_ext = {~w_s_ua & w_a_sel[A_WIDTH-1], w_a_sel};
    assign w_b_ext = {~w_s_ub & w_b[B_WIDTH-1], w_b};
    assign w_a_x   = P_W'(w_a_ext);
    assign w_b_x   = P_W'(w_b_ext);
    assign w_prod  = w_a_x * w_b_x;
    assign w_p     = ACC_W'(w_prod);

    assign w_acc_next = (w_s_load ? r_acc : '0) + (w_s_sub ? -w_p : w_p);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)       r_acc <= '0;
      else if (w_s_valid) r_acc <= w_acc_next;
    end

    // One extra bit so the rounding increment cannot wrap the sign.
    assign w_rnd_add = (r_acc_rnd && r_acc_sh != 5'd0) ? (R_W'(1) << (r_acc_sh - 5'd1)) : '0;
    assign w_r       = {r_acc[ACC_W-1], r_acc} + w_rnd_add;
    assign w_s       = $signed(w_r) >>> r_acc_sh;

    always_comb begin
      w_z = w_s[Z_W-1:0];
      if (r_acc_sat) begin
        if (r_acc_usat) begin
          if (w_s[R_W-1])      w_z = '0;
          else if (w_s > UMAX) w_z = UMAX[Z_W-1:0];
        end else begin
          if (w_s > SMAX)      w_z = SMAX[Z_W-1:0];
          else if (w_s < SMIN) w_z = SMIN[Z_W-1:0];
        end
      end
    end

    assign w_z_all[l*Z_W +: Z_W] = w_z;
  end

  if (OUT_REG) begin : g_zreg
    logic [LANES*Z_W-1:0] r_z;
    logic                 r_out_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_z         <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_acc_valid;
        if (r_acc_valid) r_z <= w_z_all;
      end
    end

    assign o_z         = r_z;
    assign o_out_valid = r_out_valid;
  end else begin : g_zcomb
    assign o_z         = w_z_all;
    assign o_out_valid = r_acc_valid;
  end

  assign o_dly_b = r_dly_b;

endmodule

// File: tb/tb_dsp_multacc_nx.sv
// Scoreboard bench: a 2-lane fully pipelined instance and a 4-lane
// unregistered instance, both checked against hand-computed lane results.
module tb_dsp_multacc_nx;

  localparam logic [79:0]  C0 = (80'(10'd100) << 20) | (80'(10'h3FC) << 60);
  localparam logic [159:0] C1 = 160'(10'd9) << 130;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [19:0] a0 = '0;
  logic [17:0] b0 = '0;
  logic [39:0] a1 = '0;
  logic [35:0] b1 = '0;
  logic [2:0]  fb = '0;
  logic        ld = 1'b0, sb = 1'b0, ua = 1'b0, ub = 1'b0, rd = 1'b0, st = 1'b0;
  logic [4:0]  sh = '0;
  logic [37:0] z0;
  logic [17:0] dly0;
  logic        ov0;
  logic [75:0] z1;
  logic [35:0] dly1;
  logic        ov1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { logic [37:0] z; int cyc; } e0_t;
  typedef struct { logic [75:0] z; int cyc; } e1_t;
  e0_t q0[$];
  e1_t q1[$];
  logic [37:0] last0 = '0;
  logic [75:0] last1 = '0;
  int la[4], lb[4], le[4];

  dsp_multacc_nx #(.LANES(2), .COEFFS(C0), .INPUT_REG_EN("TRUE"), .OUTPUT_REG_EN("TRUE")) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v0), .i_a(a0), .i_b(b0),
    .i_feedback(fb), .i_load_acc(ld), .i_subtract(sb), .i_unsigned_a(ua), .i_unsigned_b(ub),
    .i_shift_right(sh), .i_round(rd), .i_saturate(st),
    .o_z(z0), .o_dly_b(dly0), .o_out_valid(ov0));

  dsp_multacc_nx #(.LANES(4), .COEFFS(C1), .INPUT_REG_EN("FALSE"), .OUTPUT_REG_EN("FALSE")) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v1), .i_a(a1), .i_b(b1),
    .i_feedback(fb), .i_load_acc(ld), .i_subtract(sb), .i_unsigned_a(ua), .i_unsigned_b(ub),
    .i_shift_right(sh), .i_round(rd), .i_saturate(st),
    .o_z(z1), .o_dly_b(dly1), .o_out_valid(ov1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send0(input int al0, bl0, al1, bl1, input logic [2:0] f, input logic l, s, u,
                       input logic t, input logic [4:0] shr, input logic r, input int e0, e1);
    e0_t e;
    @(negedge clk);
    v0 = 1'b1; a0 = {10'(al1), 10'(al0)}; b0 = {9'(bl1), 9'(bl0)};
    fb = f; ld = l; sb = s; ua = u; ub = u; st = t; sh = shr; rd = r;
    e.z = {19'(e1), 19'(e0)};
    e.cyc = cyc + 3;
    q0.push_back(e);
  endtask

  task automatic send1(input logic [2:0] f, input logic l);
    e1_t e;
    @(negedge clk);
    v1 = 1'b1; fb = f; ld = l; sb = 1'b0; ua = 1'b0; ub = 1'b0; st = 1'b0; sh = 5'd0; rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1[i*10 +: 10] = 10'(la[i]);
      b1[i*9 +: 9]   = 9'(lb[i]);
      e.z[i*19 +: 19] = 19'(le[i]);
    end
    e.cyc = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  always @(negedge clk) begin : mon0
    e0_t e;
    if (rst_n) begin
      if (ov0) begin
        n_chk++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL ov0_unexpected: got OUT_VALID=1 expected no output");
        end else begin
          e = q0.pop_front();
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL ov0_latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
          end
          for (int l = 0; l < 2; l++) begin
            n_chk++;
            if (z0[l*19 +: 19] !== e.z[l*19 +: 19]) begin
              n_fail++;
              $display("FAIL z0_lane%0d: got %0d expected %0d", l,
                       $signed(z0[l*19 +: 19]), $signed(e.z[l*19 +: 19]));
            end
          end
          last0 = e.z;
        end
      end else begin
        n_chk++;
        if (z0 !== last0) begin
          n_fail++;
          $display("FAIL z0_hold: got %0h expected %0h", z0, last0);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    e1_t e;
    if (rst_n) begin
      if (ov1) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL ov1_unexpected: got OUT_VALID=1 expected no output");
        end else begin
          e = q1.pop_front();
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL ov1_latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
          end
          for (int l = 0; l < 4; l++) begin
            n_chk++;
            if (z1[l*19 +: 19] !== e.z[l*19 +: 19]) begin
              n_fail++;
              $display("FAIL z1_lane%0d: got %0d expected %0d", l,
                       $signed(z1[l*19 +: 19]), $signed(e.z[l*19 +: 19]));
            end
          end
          last1 = e.z;
        end
      end else begin
        n_chk++;
        if (z1 !== last1) begin
          n_fail++;
          $display("FAIL z1_hold: got %0h expected %0h", z1, last1);
        end
      end
    end
  end

  initial begin
    #1;
    check("reset_z0", 128'(z0), 128'(0));
    check("reset_ov0", 128'(ov0), 128'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // accumulate, then reset with samples still in flight
    send0(-3, 5, 2, 3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, -15, 6);
    send0(-3, 5, 2, 3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, -30, 12);
    @(negedge clk);
    v0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_z0", 128'(z0), 128'(0));
    check("rst_dly0", 128'(dly0), 128'(0));
    check("rst_ov0", 128'(ov0), 128'(0));
    check("rst_z1", 128'(z1), 128'(0));
    q0.delete(); q1.delete(); last0 = '0; last1 = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) idle();

    // signed MAC, then subtract
    send0(-3, 5, 2, 3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, -15, 6);
    send0(-3, 5, 2, 3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, -30, 12);
    send0(-3, 5, 2, 3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, -45, 18);
    send0(-3, 5, 2, 3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, -60, 24);
    send0(-3, 5, 2, 3, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, -45, 18);
    // coefficient select ignores A
    send0(55, 7, 77, 3, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 700, -12);
    // round/shift on acc=700 (lane1 acc=-12)
    send0(0, 7, 0, 3, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 88, -1);
    send0(0, 0, 0, 0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 87, -2);
    // unsigned saturate then truncate
    send0(1023, 511, 1, 1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 522753, 1);
    send0(1023, 511, 1, 1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 524287, 2);
    send0(1023, 511, 1, 1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 524287, 3);
    send0(1023, 0, 1, 0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 519683, 3);
    // signed saturate at both rails
    send0(-512, -256, -512, 255, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 131072, -130560);
    send0(-512, -256, -512, 255, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 262143, -261120);
    send0(-512, -256, -512, 255, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 262143, -262144);
    // IN_VALID gap: accumulator and DLY_B hold
    send0(1, 1, 1, 1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1, 1);
    idle();
    check("dly0_capture", 128'(dly0), 128'({9'd1, 9'd1}));
    idle();
    check("dly0_hold", 128'(dly0), 128'({9'd1, 9'd1}));
    send0(2, 3, -1, 3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 7, -2);
    repeat (4) idle();

    // 4-lane, no pipeline registers
    la = '{1, -2, 3, -4}; lb = '{5, 6, -7, 8}; le = '{5, -12, -21, -32};
    send1(3'b000, 1'b0);
    idle();
    check("dly1_capture", 128'(dly1), 128'({9'd8, 9'h1F9, 9'd6, 9'd5}));
    lb = '{1, 1, 1, 1}; le = '{6, -14, -18, -36};
    send1(3'b000, 1'b1);
    la = '{100, 100, 100, 100}; lb = '{2, 2, 2, 2}; le = '{6, -14, -18, -18};
    send1(3'b101, 1'b1);
    idle();
    idle();

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("q0_drain", 128'(q0.size()), 128'(0));
    check("q1_drain", 128'(q1.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
